// File: rtl/accel_spi3_responder_if.sv
`timescale 1ns/1ps
// accel_spi3_responder_if: 3-wire SPI pin bundle between the accelerometer master and responder.
// SDIO is split into master-driven in, responder-driven out and responder output-enable.
interface accel_spi3_responder_if;
  logic spi_sclk;
  logic spi_cs_n;
  logic spi_sdio_in;
  logic spi_sdio_out;
  logic spi_sdio_oe;

  modport master (
    output spi_sclk, spi_cs_n, spi_sdio_in,
    input  spi_sdio_out, spi_sdio_oe
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_sdio_in,
    output spi_sdio_out, spi_sdio_oe
  );
endinterface

// File: rtl/accel_spi3_responder.sv
`timescale 1ns/1ps
// accel_spi3_responder: SPI mode-3 (CPOL=1, CPHA=1) 3-wire responder emulating the board G-sensor.
// All SPI pins are oversampled in clk_clk; X/Y/Z samples come from a stimulus block.
module accel_spi3_responder #(
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  accel_spi3_responder_if.slave spi,
  input  logic signed [15:0]    sample_x,
  input  logic signed [15:0]    sample_y,
  input  logic signed [15:0]    sample_z,
  input  logic                  sample_valid,
  output logic                  int_out,
  output logic                  reg_wr_strobe,
  output logic [5:0]            reg_wr_addr,
  output logic [7:0]            reg_wr_data
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WR_DATA, S_RD_DATA} state_t;

  localparam logic [5:0] A_DEVID  = 6'h00;
  localparam logic [5:0] A_INT_EN = 6'h2E;
  localparam logic [5:0] A_STATUS = 6'h30;
  localparam logic [5:0] A_XL     = 6'h32;
  localparam logic [5:0] A_XH     = 6'h33;
  localparam logic [5:0] A_YL     = 6'h34;
  localparam logic [5:0] A_YH     = 6'h35;
  localparam logic [5:0] A_ZL     = 6'h36;
  localparam logic [5:0] A_ZH     = 6'h37;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_sdi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic                   w_sclk, w_cs, w_sdi;
  logic                   w_rise, w_fall, w_cs_fall, w_cs_rise;

  state_t                 r_state, w_state_nxt;
  logic [6:0]             r_shift;
  logic [2:0]             r_bit_cnt;
  logic                   r_mb;
  logic [5:0]             r_addr;
  logic [6:0]             r_tx;
  logic                   r_sdo, r_oe;

  logic [7:0]             r_regs [0:63];
  logic                   r_dr;
  logic                   r_pend_vld;
  logic signed [15:0]     r_pend_x, r_pend_y, r_pend_z;
  logic                   r_wr_strobe;
  logic [5:0]             r_wr_addr;
  logic [7:0]             r_wr_data;
  logic                   r_int;

  logic [7:0]             w_byte_in, w_rd_byte;
  logic                   w_wr_done, w_rd_done, w_wr_ro, w_addr_is_sample;
  logic                   w_smp_direct, w_smp_load;
  logic signed [15:0]     w_ld_x, w_ld_y, w_ld_z;

  assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs      = r_cs_sync[SYNC_STAGES-1];
  assign w_sdi     = r_sdi_sync[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d & ~w_cs;
  assign w_fall    = ~w_sclk & r_sclk_d & ~w_cs;
  assign w_cs_fall = r_cs_d & ~w_cs;
  assign w_cs_rise = ~r_cs_d & w_cs;

  assign w_byte_in = {r_shift, w_sdi};
  assign w_wr_done = (r_state == S_WR_DATA) && w_rise && (r_bit_cnt == 3'd7);
  assign w_rd_done = (r_state == S_RD_DATA) && w_fall && (r_bit_cnt == 3'd7);

  assign w_addr_is_sample = (r_addr >= A_XL) && (r_addr <= A_ZH);
  assign w_wr_ro          = (r_addr == A_DEVID) || (r_addr == A_STATUS) || w_addr_is_sample;

  // A sample seen while deselected loads at once; a pending one lands on deselect so reads never tear
  assign w_smp_direct = sample_valid & w_cs;
  assign w_smp_load   = w_smp_direct | (w_cs_rise & r_pend_vld);
  assign w_ld_x       = w_smp_direct ? sample_x : r_pend_x;
  assign w_ld_y       = w_smp_direct ? sample_y : r_pend_y;
  assign w_ld_z       = w_smp_direct ? sample_z : r_pend_z;

  assign spi.spi_sdio_out = r_sdo;
  assign spi.spi_sdio_oe  = r_oe;
  assign int_out          = r_int;
  assign reg_wr_strobe    = r_wr_strobe;
  assign reg_wr_addr      = r_wr_addr;
  assign reg_wr_data      = r_wr_data;

  // Synchronize the SPI pins and keep one cycle of history for edge detection
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_sclk_sync <= '1;
      r_cs_sync   <= '1;
      r_sdi_sync  <= '0;
      r_sclk_d    <= 1'b1;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi.spi_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi.spi_cs_n};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], spi.spi_sdio_in};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  // Transaction state register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Next state: command byte picks read or write; deselect always returns to idle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cs_fall) w_state_nxt = S_CMD;
      S_CMD:   if (w_rise && (r_bit_cnt == 3'd7)) w_state_nxt = r_shift[6] ? S_RD_DATA : S_WR_DATA;
      default: w_state_nxt = r_state;
    endcase
    if (w_cs_rise) w_state_nxt = S_IDLE;
  end

  // Register map read view: DEVID and status are synthesized, everything else is storage
  always_comb begin
    w_rd_byte = r_regs[r_addr];
    if (r_addr == A_DEVID)       w_rd_byte = DEVID;
    else if (r_addr == A_STATUS) w_rd_byte = {r_dr, 7'b0};
  end

  // Shift bits in on sclk rises, shift read data out on falls, sequence the address
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_mb      <= 1'b0;
      r_addr    <= '0;
      r_tx      <= '0;
      r_sdo     <= 1'b0;
      r_oe      <= 1'b0;
    end else if (w_cs_rise || w_cs_fall) begin
      r_bit_cnt <= '0;
      r_sdo     <= 1'b0;
      r_oe      <= 1'b0;
    end else begin
      if (w_rise && ((r_state == S_CMD) || (r_state == S_WR_DATA))) begin
        r_shift   <= w_byte_in[6:0];
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if ((r_state == S_CMD) && (r_bit_cnt == 3'd7)) begin
          r_mb   <= r_shift[5];
          r_addr <= w_byte_in[5:0];
        end
        if (w_wr_done && r_mb) r_addr <= r_addr + 6'd1;
      end
      if (w_fall && (r_state == S_RD_DATA)) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd0) begin
          r_oe  <= 1'b1;
          r_sdo <= w_rd_byte[7];
          r_tx  <= w_rd_byte[6:0];
        end else begin
          r_sdo <= r_tx[6];
          r_tx  <= {r_tx[5:0], 1'b0};
        end
        if ((r_bit_cnt == 3'd7) && r_mb) r_addr <= r_addr + 6'd1;
      end
    end
  end

  // Register file, write commit strobe, sample capture and DATA_READY tracking
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 64; i++) r_regs[i] <= '0;
      r_dr        <= 1'b0;
      r_pend_vld  <= 1'b0;
      r_pend_x    <= '0;
      r_pend_y    <= '0;
      r_pend_z    <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_wr_strobe <= w_wr_done;
      if (w_wr_done) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_byte_in;
        if (!w_wr_ro) r_regs[r_addr] <= w_byte_in;
      end
      if (w_cs_rise) r_pend_vld <= 1'b0;
      if (sample_valid && !w_cs) begin
        r_pend_vld <= 1'b1;
        r_pend_x   <= sample_x;
        r_pend_y   <= sample_y;
        r_pend_z   <= sample_z;
      end
      if (w_smp_load) begin
        r_regs[A_XL] <= w_ld_x[7:0];
        r_regs[A_XH] <= w_ld_x[15:8];
        r_regs[A_YL] <= w_ld_y[7:0];
        r_regs[A_YH] <= w_ld_y[15:8];
        r_regs[A_ZL] <= w_ld_z[7:0];
        r_regs[A_ZH] <= w_ld_z[15:8];
        r_dr         <= 1'b1;
      end else if (w_rd_done && w_addr_is_sample) begin
        r_dr <= 1'b0;
      end
    end
  end

  // Data-ready interrupt, gated by the enable bit
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) r_int <= 1'b0;
    else                r_int <= r_dr & r_regs[A_INT_EN][7];
  end

endmodule

// File: tb/tb_accel_spi3_responder.sv
`timescale 1ns/1ps
// tb_accel_spi3_responder: directed SPI mode-3 transactions checked against a register-map model.
module tb_accel_spi3_responder;
  localparam int HALF = 8;

  logic               clk_clk       = 1'b0;
  logic               reset_reset_n = 1'b0;
  logic signed [15:0] sample_x      = '0;
  logic signed [15:0] sample_y      = '0;
  logic signed [15:0] sample_z      = '0;
  logic               sample_valid  = 1'b0;
  logic               int_out;
  logic               reg_wr_strobe;
  logic [5:0]         reg_wr_addr;
  logic [7:0]         reg_wr_data;

  accel_spi3_responder_if spi_bus();

  accel_spi3_responder #(.DEVID(8'hE5), .SYNC_STAGES(2)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .spi           (spi_bus),
    .sample_x      (sample_x),
    .sample_y      (sample_y),
    .sample_z      (sample_z),
    .sample_valid  (sample_valid),
    .int_out       (int_out),
    .reg_wr_strobe (reg_wr_strobe),
    .reg_wr_addr   (reg_wr_addr),
    .reg_wr_data   (reg_wr_data)
  );

  always #5 clk_clk = ~clk_clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          n_strobe = 0;
  logic [13:0] last_wr = '0;
  logic        chk_en = 1'b0;

  // model of the register map as the master sees it
  logic [7:0]  m_regs [64];
  logic        m_dr;
  logic        m_pend_vld;
  logic [15:0] m_px, m_py, m_pz;
  logic [13:0] got_q [$];
  logic [13:0] exp_q [$];
  logic [7:0]  rx [8];
  logic [7:0]  tx [8];
  logic [15:0] inj_x, inj_y, inj_z;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic is_sample(input logic [5:0] a);
    return (a >= 6'h32) && (a <= 6'h37);
  endfunction

  function automatic logic is_ro(input logic [5:0] a);
    return (a == 6'h00) || (a == 6'h30) || is_sample(a);
  endfunction

  function automatic logic [7:0] model_read(input logic [5:0] a);
    if (a == 6'h00) return 8'hE5;
    if (a == 6'h30) return {m_dr, 7'b0};
    return m_regs[a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_regs[i] = 8'h00;
    m_dr = 1'b0; m_pend_vld = 1'b0; m_px = '0; m_py = '0; m_pz = '0;
  endtask

  task automatic model_load(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    m_regs[6'h32] = x[7:0]; m_regs[6'h33] = x[15:8];
    m_regs[6'h34] = y[7:0]; m_regs[6'h35] = y[15:8];
    m_regs[6'h36] = z[7:0]; m_regs[6'h37] = z[15:8];
    m_dr = 1'b1;
  endtask

  // per-cycle comparison while the bus is quiet
  always @(negedge clk_clk) begin
    if (chk_en) begin
      chk("idle_int_out", 32'(int_out), 32'(m_dr & m_regs[6'h2E][7]));
      chk("idle_oe", 32'(spi_bus.spi_sdio_oe), 0);
    end
  end

  always @(negedge clk_clk) begin
    if (reg_wr_strobe === 1'b1) begin
      got_q.push_back({reg_wr_addr, reg_wr_data});
      last_wr = {reg_wr_addr, reg_wr_data};
      n_strobe++;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check_strobes();
    chk("wr_strobe_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; (i < got_q.size()) && (i < exp_q.size()); i++)
      chk("wr_addr_data", 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic spi_bit(input logic din, output logic dout, output logic oe);
    spi_bus.spi_sclk    = 1'b0;
    spi_bus.spi_sdio_in = din;
    repeat (HALF) @(negedge clk_clk);
    dout = spi_bus.spi_sdio_out;
    oe   = spi_bus.spi_sdio_oe;
    spi_bus.spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk_clk);
  endtask

  task automatic spi_byte(input logic [7:0] din, output logic [7:0] dout,
                          output logic oe_lo, output logic oe_hi);
    logic b, o;
    oe_lo = 1'b1; oe_hi = 1'b0; dout = '0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(din[i], b, o);
      dout[i] = b;
      oe_lo   = oe_lo & o;
      oe_hi   = oe_hi | o;
    end
  endtask

  task automatic spi_begin();
    chk_en = 1'b0;
    spi_bus.spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk_clk);
  endtask

  task automatic spi_end(input logic was_rd);
    spi_bus.spi_cs_n = 1'b1;
    @(negedge clk_clk);
    @(negedge clk_clk);
    chk("oe_hold_after_cs", 32'(spi_bus.spi_sdio_oe), 32'(was_rd));
    @(negedge clk_clk);
    chk("oe_drop_after_cs", 32'(spi_bus.spi_sdio_oe), 0);
    if (m_pend_vld) begin
      model_load(m_px, m_py, m_pz);
      m_pend_vld = 1'b0;
    end
    repeat (HALF) @(negedge clk_clk);
    check_strobes();
    chk_en = 1'b1;
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                              output logic i1, output logic i2);
    logic save;
    save = chk_en; chk_en = 1'b0;
    sample_x = x; sample_y = y; sample_z = z; sample_valid = 1'b1;
    @(negedge clk_clk);
    sample_valid = 1'b0;
    i1 = int_out;
    @(negedge clk_clk);
    i2 = int_out;
    if (spi_bus.spi_cs_n) model_load(x, y, z);
    else begin
      m_px = x; m_py = y; m_pz = z; m_pend_vld = 1'b1;
    end
    chk_en = save;
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int n, input int inj);
    logic [7:0] d;
    logic lo, hi, i1, i2;
    logic [5:0] a;
    spi_begin();
    a = cmd[5:0];
    spi_byte(cmd, d, lo, hi);
    chk("cmd_oe", 32'(hi), 0);
    for (int k = 0; k < n; k++) begin
      if (k == inj) pulse_sample(inj_x, inj_y, inj_z, i1, i2);
      spi_byte(8'h00, d, lo, hi);
      chk("rd_byte", 32'(d), 32'(model_read(a)));
      chk("rd_oe", 32'(lo), 1);
      rx[k] = d;
      if (is_sample(a)) m_dr = 1'b0;
      if (cmd[6]) a = a + 6'd1;
    end
    spi_end(1'b1);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input int n);
    logic [7:0] d;
    logic lo, hi;
    logic [5:0] a;
    spi_begin();
    a = cmd[5:0];
    spi_byte(cmd, d, lo, hi);
    chk("cmd_oe", 32'(hi), 0);
    for (int k = 0; k < n; k++) begin
      spi_byte(tx[k], d, lo, hi);
      chk("wr_oe", 32'(hi), 0);
      exp_q.push_back({a, tx[k]});
      if (!is_ro(a)) m_regs[a] = tx[k];
      if (cmd[6]) a = a + 6'd1;
    end
    spi_end(1'b0);
  endtask

  initial begin
    logic [7:0] d;
    logic lo, hi, b, o, i1, i2;
    logic [7:0] lit6 [6];
    int s0;
    lit6 = '{8'h23, 8'h01, 8'h80, 8'hFF, 8'hFF, 8'h7F};
    spi_bus.spi_sclk = 1'b1; spi_bus.spi_cs_n = 1'b1; spi_bus.spi_sdio_in = 1'b0;
    model_reset();
    repeat (3) @(negedge clk_clk);
    chk("rst_oe", 32'(spi_bus.spi_sdio_oe), 0);
    chk("rst_sdo", 32'(spi_bus.spi_sdio_out), 0);
    chk("rst_int", 32'(int_out), 0);
    chk("rst_strobe", 32'(reg_wr_strobe), 0);
    chk("rst_addr", 32'(reg_wr_addr), 0);
    chk("rst_data", 32'(reg_wr_data), 0);
    reset_reset_n = 1'b1;
    repeat (4) @(negedge clk_clk);
    chk_en = 1'b1;

    // DEVID read
    spi_read(8'h80, 1, -1);
    chk("devid_lit", 32'(rx[0]), 32'h0000_00E5);

    // interrupt enable then a sample while deselected
    tx[0] = 8'h80; spi_write(8'h2E, 1);
    chk("wr_2e_lit", 32'(last_wr), 32'({6'h2E, 8'h80}));
    pulse_sample(16'h0123, 16'hFF80, 16'h7FFF, i1, i2);
    chk("int_1clk_lit", 32'(i1), 0);
    chk("int_2clk_lit", 32'(i2), 1);

    // multi-byte sample read clears DATA_READY
    spi_read(8'hF2, 6, -1);
    for (int k = 0; k < 6; k++) chk("mb_read_lit", 32'(rx[k]), 32'(lit6[k]));
    chk("int_after_mb_lit", 32'(int_out), 0);

    // sample mid-read is held off until deselect
    inj_x = 16'h1111; inj_y = 16'h2222; inj_z = 16'h3333;
    spi_read(8'hF2, 6, 2);
    for (int k = 0; k < 6; k++) chk("no_tear_lit", 32'(rx[k]), 32'(lit6[k]));
    chk("int_pend_apply_lit", 32'(int_out), 1);
    spi_read(8'hF2, 2, -1);
    chk("reread_xl_lit", 32'(rx[0]), 32'h11);
    chk("reread_xh_lit", 32'(rx[1]), 32'h11);

    // status register reflects DATA_READY without clearing it
    pulse_sample(16'hABCD, 16'h8000, 16'h0001, i1, i2);
    spi_read(8'hB0, 1, -1);
    chk("status_lit", 32'(rx[0]), 32'h80);

    // address wrap 0x3F -> 0x00
    tx[0] = 8'h5A; spi_write(8'h3F, 1);
    spi_read(8'hFF, 2, -1);
    chk("wrap0_lit", 32'(rx[0]), 32'h5A);
    chk("wrap1_lit", 32'(rx[1]), 32'hE5);

    // read-only write still strobes, storage unchanged
    tx[0] = 8'hAA; spi_write(8'h32, 1);
    chk("ro_strobe_lit", 32'(last_wr), 32'({6'h32, 8'hAA}));
    spi_read(8'hB2, 1, -1);
    chk("ro_keep_lit", 32'(rx[0]), 32'hCD);

    // multi-byte write, then single-address repeated read
    tx[0] = 8'h10; tx[1] = 8'h20; spi_write(8'h41, 2);
    spi_read(8'h81, 2, -1);
    chk("nomb0_lit", 32'(rx[0]), 32'h10);
    chk("nomb1_lit", 32'(rx[1]), 32'h10);
    spi_read(8'hC1, 2, -1);
    chk("mb_after_wr_lit", 32'(rx[1]), 32'h20);

    // partial byte discarded on deselect
    s0 = n_strobe;
    spi_begin();
    spi_byte(8'h05, d, lo, hi);
    for (int i = 0; i < 4; i++) spi_bit(1'b1, b, o);
    spi_end(1'b0);
    chk("abort_no_strobe", 32'(n_strobe - s0), 0);
    spi_read(8'h85, 1, -1);
    chk("abort_reg_lit", 32'(rx[0]), 32'h00);

    // asynchronous reset in the middle of a read
    pulse_sample(16'h0F0F, 16'h0000, 16'h0000, i1, i2);
    chk("int_before_rst_lit", 32'(int_out), 1);
    spi_begin();
    spi_byte(8'h81, d, lo, hi);
    for (int i = 0; i < 3; i++) spi_bit(1'b0, b, o);
    chk("oe_mid_read", 32'(o), 1);
    #3 reset_reset_n = 1'b0;
    #1;
    chk("oe_async_rst", 32'(spi_bus.spi_sdio_oe), 0);
    chk("int_async_rst", 32'(int_out), 0);
    model_reset();
    got_q.delete(); exp_q.delete();
    spi_bus.spi_cs_n = 1'b1; spi_bus.spi_sclk = 1'b1;
    repeat (3) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (HALF) @(negedge clk_clk);
    chk_en = 1'b1;
    spi_read(8'h81, 1, -1);
    chk("post_rst_01_lit", 32'(rx[0]), 32'h00);
    spi_read(8'hAE, 1, -1);
    chk("post_rst_2e_lit", 32'(rx[0]), 32'h00);
    spi_read(8'hB2, 1, -1);
    chk("post_rst_32_lit", 32'(rx[0]), 32'h00);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
